// File: rtl/fighter_state_ctrl.sv
// Per-fighter action controller: a tick-driven state machine with hit, attack and dodge timers plus ledge cooldown.
// Optional AIR_DODGE_EN allows one dodge per airtime.
module fighter_state_ctrl #(
  parameter int unsigned VEL_W        = 8,
  parameter int unsigned ANIM_W       = 6,
  parameter int unsigned STUN_W       = 6,
  parameter int unsigned ATK_FRAMES   = 12,
  parameter int unsigned DODGE_FRAMES = 10,
  parameter int unsigned LEDGE_CD     = 30,
  parameter int unsigned WALK_SPEED   = 3,
  parameter int unsigned DODGE_SPEED  = 6,
  parameter int unsigned JUMP_VEL     = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    near_ledge,
  input  logic                    grounded,
  input  logic                    btn_atk,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    hit_valid,
  input  logic [STUN_W-1:0]       hit_stun_frames,
  input  logic signed [VEL_W-1:0] hit_kb_x,
  input  logic signed [VEL_W-1:0] hit_kb_y,
  output logic signed [VEL_W-1:0] x_velocity,
  output logic signed [VEL_W-1:0] y_velocity,
  output logic [ANIM_W-1:0]       anim_id,
  output logic [2:0]              state_out,
  output logic                    facing
);

  localparam int unsigned ATK_W = $clog2(ATK_FRAMES + 1);
  localparam int unsigned DG_W  = $clog2(DODGE_FRAMES + 1);
  localparam int unsigned SEQ_W = (ATK_W > DG_W) ? ATK_W : DG_W;
  localparam int unsigned TMR_W = (STUN_W > SEQ_W) ? STUN_W : SEQ_W;
  localparam int unsigned CD_W  = (LEDGE_CD > 0) ? $clog2(LEDGE_CD + 1) : 1;

  localparam logic signed [VEL_W-1:0] WALK_V  = VEL_W'(WALK_SPEED);
  localparam logic signed [VEL_W-1:0] DODGE_V = VEL_W'(DODGE_SPEED);
  localparam logic signed [VEL_W-1:0] JUMP_V  = VEL_W'(JUMP_VEL);

  typedef enum logic [2:0] {
    ST_MOVE   = 3'd0,
    ST_ATTACK = 3'd1,
    ST_DODGE  = 3'd2,
    ST_SHIELD = 3'd3,
    ST_LEDGE  = 3'd4,
    ST_HIT    = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [CD_W-1:0]         cd_q, cd_d;
  logic                    hit_pend_q, hit_pend_d;
  logic [STUN_W-1:0]       stun_cap_q, stun_cap_d;
  logic signed [VEL_W-1:0] kbx_cap_q, kbx_cap_d, kby_cap_q, kby_cap_d;
  logic signed [VEL_W-1:0] kbx_q, kbx_d, kby_q, kby_d;
  logic                    atk_prev_q, atk_prev_d;
  logic                    facing_q, facing_d;
  logic signed [VEL_W-1:0] dodge_vx_q, dodge_vx_d;
  logic signed [VEL_W-1:0] xv_q, xv_d, yv_q, yv_d;
  logic [ANIM_W-1:0]       anim_q, anim_d;
`ifdef AIR_DODGE_EN
  logic                    air_used_q, air_used_d;
  logic                    dodge_air_q, dodge_air_d;
`endif

  logic                    ledge_jump;
  logic [STUN_W-1:0]       stun_eff;
  logic signed [VEL_W-1:0] kbx_eff, kby_eff;

  // Next-state, timers and registered outputs; everything but the hit latch moves only on frame_tick
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cd_d       = cd_q;
    hit_pend_d = hit_pend_q;
    stun_cap_d = stun_cap_q;
    kbx_cap_d  = kbx_cap_q;
    kby_cap_d  = kby_cap_q;
    kbx_d      = kbx_q;
    kby_d      = kby_q;
    atk_prev_d = atk_prev_q;
    facing_d   = facing_q;
    dodge_vx_d = dodge_vx_q;
    xv_d       = xv_q;
    yv_d       = yv_q;
    anim_d     = anim_q;
`ifdef AIR_DODGE_EN
    air_used_d  = air_used_q;
    dodge_air_d = dodge_air_q;
`endif
    ledge_jump = 1'b0;
    // A hit arriving on the tick cycle itself is applied immediately
    stun_eff   = hit_valid ? hit_stun_frames : stun_cap_q;
    kbx_eff    = hit_valid ? hit_kb_x : kbx_cap_q;
    kby_eff    = hit_valid ? hit_kb_y : kby_cap_q;

    if (hit_valid) begin
      hit_pend_d = 1'b1;
      stun_cap_d = hit_stun_frames;
      kbx_cap_d  = hit_kb_x;
      kby_cap_d  = hit_kb_y;
    end

    if (frame_tick) begin
      atk_prev_d = btn_atk;
      if (cd_q != '0) cd_d = cd_q - CD_W'(1);
`ifdef AIR_DODGE_EN
      if (grounded) air_used_d = 1'b0;
`endif
      if (hit_valid || hit_pend_q) begin
        state_d    = ST_HIT;
        timer_d    = (stun_eff == '0) ? TMR_W'(1) : TMR_W'(stun_eff);
        kbx_d      = kbx_eff;
        kby_d      = kby_eff;
        hit_pend_d = 1'b0;
      end else if (state_q inside {ST_HIT, ST_ATTACK, ST_DODGE}) begin
        timer_d = timer_q - TMR_W'(1);
        if (timer_q <= TMR_W'(1)) state_d = ST_MOVE;
      end else if (state_q == ST_LEDGE) begin
        if (btn_up) begin
          state_d    = ST_MOVE;
          ledge_jump = 1'b1;
          cd_d       = CD_W'(LEDGE_CD);
        end else if (btn_down) begin
          state_d = ST_MOVE;
          cd_d    = CD_W'(LEDGE_CD);
        end
      end else if (near_ledge && !grounded && (cd_q == '0)) begin
        state_d = ST_LEDGE;
      end else if (btn_atk && !atk_prev_q) begin
        state_d = ST_ATTACK;
        timer_d = TMR_W'(ATK_FRAMES);
      end else if (btn_down && grounded && (btn_left ^ btn_right)) begin
        state_d    = ST_DODGE;
        timer_d    = TMR_W'(DODGE_FRAMES);
        dodge_vx_d = btn_right ? DODGE_V : -DODGE_V;
`ifdef AIR_DODGE_EN
        dodge_air_d = 1'b0;
      end else if (btn_down && !grounded && !air_used_q) begin
        state_d     = ST_DODGE;
        timer_d     = TMR_W'(DODGE_FRAMES);
        dodge_vx_d  = (btn_left ^ btn_right) ? (btn_right ? DODGE_V : -DODGE_V) : '0;
        air_used_d  = 1'b1;
        dodge_air_d = 1'b1;
`endif
      end else if (btn_down && grounded) begin
        state_d = ST_SHIELD;
      end else begin
        state_d = ST_MOVE;
      end

      xv_d   = '0;
      yv_d   = '0;
      anim_d = '0;
      case (state_d)
        ST_MOVE: begin
          if (btn_right && !btn_left)      xv_d = WALK_V;
          else if (btn_left && !btn_right) xv_d = -WALK_V;
          if (ledge_jump || (btn_up && grounded)) yv_d = JUMP_V;
          if (!grounded)        anim_d = ANIM_W'(2);
          else if (xv_d != '0)  anim_d = ANIM_W'(1);
          if (btn_left ^ btn_right) facing_d = btn_right;
        end
        ST_ATTACK: anim_d = ANIM_W'(4);
        ST_DODGE: begin
          xv_d   = dodge_vx_d;
`ifdef AIR_DODGE_EN
          anim_d = dodge_air_d ? ANIM_W'(9) : ANIM_W'(5);
`else
          anim_d = ANIM_W'(5);
`endif
        end
        ST_SHIELD: anim_d = ANIM_W'(6);
        ST_LEDGE:  anim_d = ANIM_W'(7);
        ST_HIT: begin
          xv_d   = kbx_d;
          yv_d   = kby_d;
          anim_d = ANIM_W'(8);
        end
        default: anim_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_MOVE;
      timer_q     <= '0;
      cd_q        <= '0;
      hit_pend_q  <= 1'b0;
      stun_cap_q  <= '0;
      kbx_cap_q   <= '0;
      kby_cap_q   <= '0;
      kbx_q       <= '0;
      kby_q       <= '0;
      atk_prev_q  <= 1'b0;
      facing_q    <= 1'b1;
      dodge_vx_q  <= '0;
      xv_q        <= '0;
      yv_q        <= '0;
      anim_q      <= '0;
`ifdef AIR_DODGE_EN
      air_used_q  <= 1'b0;
      dodge_air_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cd_q        <= cd_d;
      hit_pend_q  <= hit_pend_d;
      stun_cap_q  <= stun_cap_d;
      kbx_cap_q   <= kbx_cap_d;
      kby_cap_q   <= kby_cap_d;
      kbx_q       <= kbx_d;
      kby_q       <= kby_d;
      atk_prev_q  <= atk_prev_d;
      facing_q    <= facing_d;
      dodge_vx_q  <= dodge_vx_d;
      xv_q        <= xv_d;
      yv_q        <= yv_d;
      anim_q      <= anim_d;
`ifdef AIR_DODGE_EN
      air_used_q  <= air_used_d;
      dodge_air_q <= dodge_air_d;
`endif
    end
  end

  assign x_velocity = xv_q;
  assign y_velocity = yv_q;
  assign anim_id    = anim_q;
  assign state_out  = state_q;
  assign facing     = facing_q;

endmodule
